// File: rtl/tlb_miss_walker_pkg.sv
// Shared types and constants for the TLB miss page-table walker.
// tlb_req_info_t is the same fill payload the TLB already consumes.
package tlb_miss_walker_pkg;

    localparam int TLB_VA_W        = 32;
    localparam int TLB_PA_W        = 20;
    localparam int TLB_PAGE_OFFSET = 12;
    localparam int TLB_THR_W       = 2;
    localparam int TLB_PPN_W       = TLB_PA_W - TLB_PAGE_OFFSET;

    // Physical byte address of the single-level page table (4-byte entries, indexed by VPN).
    localparam logic [TLB_PA_W-1:0] TLB_PT_BASE = 20'h08000;

    // PTE field positions inside the 32-bit memory word.
    localparam int PTE_VALID_BIT = 31;
    localparam int PTE_WRITE_BIT = 30;

    typedef struct packed {
        logic [TLB_VA_W-1:0] virt_addr;
        logic [TLB_PA_W-1:0] phy_addr;
    } tlb_req_info_t;

    typedef struct packed {
        logic                 valid;
        logic                 write;
        logic [TLB_PPN_W-1:0] ppn;
    } pte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL,
        ST_FAULT
    } walker_state_t;

endpackage

// File: rtl/tlb_miss_walker.sv
// Single-level hardware page-table walker feeding the TLB fill port.
// Accepts one miss at a time, reads its PTE, then either fills the TLB or
// raises a page fault for one cycle before returning to idle.
module tlb_miss_walker
    import tlb_miss_walker_pkg::*;
#(
    parameter int                  VA_WIDTH    = TLB_VA_W,
    parameter int                  PA_WIDTH    = TLB_PA_W,
    parameter int                  PAGE_OFFSET = TLB_PAGE_OFFSET,
    parameter int                  THR_W       = TLB_THR_W,
    parameter logic [PA_WIDTH-1:0] PT_BASE     = TLB_PT_BASE
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                miss_valid,
    input  logic [THR_W-1:0]    miss_thread_id,
    input  logic [VA_WIDTH-1:0] miss_virt_addr,
    output logic                miss_ready,

    output logic                mem_req_valid,
    output logic [PA_WIDTH-1:0] mem_req_addr,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [31:0]         mem_rsp_data,

    output logic                new_tlb_entry,
    output logic [THR_W-1:0]    new_tlb_thread_id,
    output tlb_req_info_t       new_tlb_info,
    output logic                new_tlb_write,
    output logic                page_fault,
    output logic [VA_WIDTH-1:0] fault_virt_addr
);

    localparam int PPN_W = PA_WIDTH - PAGE_OFFSET;
    localparam int VPN_W = VA_WIDTH - PAGE_OFFSET;

    walker_state_t       state_q;
    walker_state_t       state_d;

    logic [THR_W-1:0]    thr_q;
    logic [VA_WIDTH-1:0] va_q;
    logic                pte_write_q;
    logic [PPN_W-1:0]    pte_ppn_q;

    pte_t                rsp_pte;
    logic [VPN_W-1:0]    vpn;
    logic                unused_pte_bits;

    // Only valid, write and PPN are architecturally defined; the rest is ignored.
    assign rsp_pte.valid   = mem_rsp_data[PTE_VALID_BIT];
    assign rsp_pte.write   = mem_rsp_data[PTE_WRITE_BIT];
    assign rsp_pte.ppn     = mem_rsp_data[PPN_W-1:0];
    assign unused_pte_bits = ^mem_rsp_data[PTE_WRITE_BIT-1:PPN_W];

    // PTE address is derived from the captured VA, so it stays stable under backpressure.
    assign vpn          = va_q[VA_WIDTH-1:PAGE_OFFSET];
    assign mem_req_addr = PT_BASE + PA_WIDTH'({vpn, 2'b00});

    // Fill/fault payload comes straight from the capture registers and holds between strobes.
    assign new_tlb_thread_id = thr_q;
    assign new_tlb_write     = pte_write_q;
    assign fault_virt_addr   = va_q;
    assign new_tlb_info      = '{virt_addr: va_q,
                                 phy_addr:  {pte_ppn_q, va_q[PAGE_OFFSET-1:0]}};

    // State register; reset returns to idle, which also drops any in-flight response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode for the walk sequence.
    always_comb begin
        state_d       = state_q;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        new_tlb_entry = 1'b0;
        page_fault    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = rsp_pte.valid ? ST_FILL : ST_FAULT;
                end
            end
            ST_FILL: begin
                new_tlb_entry = 1'b1;
                state_d       = ST_IDLE;
            end
            ST_FAULT: begin
                page_fault = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the miss on acceptance and the PTE fields when the response lands.
    always_ff @(posedge clock) begin
        if (!reset) begin
            thr_q       <= '0;
            va_q        <= '0;
            pte_write_q <= 1'b0;
            pte_ppn_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && miss_valid) begin
                thr_q <= miss_thread_id;
                va_q  <= miss_virt_addr;
            end
            if (state_q == ST_WAIT && mem_rsp_valid) begin
                pte_write_q <= rsp_pte.write;
                pte_ppn_q   <= rsp_pte.ppn;
            end
        end
    end

    // A response colliding with the request handshake is a memory protocol violation.
    assert property (@(posedge clock) disable iff (!reset)
        !(state_q == ST_REQ && mem_req_ready && mem_rsp_valid));

endmodule
